// File: rtl/rangefinder_shot_sequencer.sv
// -----------------------------------------------------------------------------
// rangefinder_shot_sequencer
//   Runs one laser measurement shot, or a burst of them:
//     CHARGE -> ARM -> FIRE -> WAIT_STOP -> (READOUT) -> COOLDOWN
//   and posts one result per shot (TDC value, or a timeout marker).
//   An APD overcurrent forces a sticky FAULT state that drops every drive
//   output. Abort returns to IDLE, except that an in-flight TDC readout is
//   always allowed to finish so the SPI handshake is never left dangling.
//   Every output is a flop; the phase drive outputs are held in one packed
//   register that is loaded with the decode of the state being entered.
// -----------------------------------------------------------------------------
module rangefinder_shot_sequencer #(
  parameter int CNT_W           = 16,
  parameter int CHARGE_CYCLES   = 2000,
  parameter int ARM_CYCLES      = 50,
  parameter int FIRE_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES  = 10000,
  parameter int COOLDOWN_CYCLES = 5000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        shot_req,
  input  logic [7:0]  burst_len,
  input  logic        abort,
  input  logic        apd_overcurrent,
  input  logic        fault_clr,
  input  logic        comparator_hit,
  output logic        charge_en,
  output logic        tdc_enable,
  output logic        fire,
  output logic        rd_req,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic        result_valid,
  output logic [31:0] result_data,
  output logic        result_timeout,
  output logic [7:0]  shots_done,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGE,
    S_ARM,
    S_FIRE,
    S_WAIT_STOP,
    S_READOUT,
    S_COOLDOWN,
    S_FAULT
  } state_t;

  // Per-state level outputs, registered together so they switch on the same
  // edge as the state itself.
  typedef struct packed {
    logic charge_en;
    logic tdc_enable;
    logic fire;
    logic rd_req;
    logic busy;
    logic fault;
  } drive_t;

  // Terminal timer values: a phase of N cycles ends when the timer shows N-1.
  localparam logic [CNT_W-1:0] CHARGE_LAST   = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_LAST      = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRE_LAST     = CNT_W'(FIRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE     = CNT_W'(1);

  state_t           state;
  drive_t           drv;
  logic [CNT_W-1:0] timer;
  logic [7:0]       burst_target;
  logic             abort_pending;
  logic [7:0]       shots_next;

  // Level outputs that belong to each state.
  function automatic drive_t drive_of(input state_t s);
    drive_t d;
    // NOTE: a full default before the case keeps every field assigned on
    // every path, so no latch or stale value can creep in.
    d = '0;
    case (s)
      S_CHARGE:    begin d.charge_en  = 1'b1; d.busy = 1'b1; end
      S_ARM:       begin d.tdc_enable = 1'b1; d.busy = 1'b1; end
      S_FIRE:      begin d.tdc_enable = 1'b1; d.fire = 1'b1; d.busy = 1'b1; end
      S_WAIT_STOP: begin d.tdc_enable = 1'b1; d.busy = 1'b1; end
      S_READOUT:   begin d.rd_req     = 1'b1; d.busy = 1'b1; end
      S_COOLDOWN:  d.busy  = 1'b1;
      S_FAULT:     d.fault = 1'b1;
      default:     d = '0;
    endcase
    return d;
  endfunction

  // Shot counter value after posting one more result, saturating at 255.
  assign shots_next = (shots_done == 8'hFF) ? 8'hFF : shots_done + 8'd1;

  assign charge_en  = drv.charge_en;
  assign tdc_enable = drv.tdc_enable;
  assign fire       = drv.fire;
  assign rd_req     = drv.rd_req;
  assign busy       = drv.busy;
  assign fault      = drv.fault;

  // Shot sequencer: state, phase timer, burst bookkeeping and result registers.
  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= S_IDLE;
      drv            <= '0;
      timer          <= '0;
      burst_target   <= '0;
      abort_pending  <= 1'b0;
      shots_done     <= '0;
      result_valid   <= 1'b0;
      result_timeout <= 1'b0;
      result_data    <= '0;
    end else begin
      // Strobe defaults low; the timer free-runs and is cleared on phase entry.
      result_valid <= 1'b0;
      timer        <= timer + TIMER_ONE;

      if (apd_overcurrent) begin
        // Overcurrent beats everything: drop drives, discard any pending result.
        state         <= S_FAULT;
        drv           <= drive_of(S_FAULT);
        timer         <= '0;
        abort_pending <= 1'b0;
      end else if (state == S_FAULT) begin
        timer <= '0;
        if (fault_clr) begin
          state <= S_IDLE;
          drv   <= drive_of(S_IDLE);
        end
      end else if (abort && (state != S_READOUT)) begin
        state         <= S_IDLE;
        drv           <= drive_of(S_IDLE);
        timer         <= '0;
        abort_pending <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            timer <= '0;
            if (shot_req) begin
              burst_target <= (burst_len == 8'd0) ? 8'd1 : burst_len;
              shots_done   <= '0;
              state        <= S_CHARGE;
              drv          <= drive_of(S_CHARGE);
            end
          end

          S_CHARGE: begin
            if (timer == CHARGE_LAST) begin
              state <= S_ARM;
              drv   <= drive_of(S_ARM);
              timer <= '0;
            end
          end

          S_ARM: begin
            if (timer == ARM_LAST) begin
              state <= S_FIRE;
              drv   <= drive_of(S_FIRE);
              timer <= '0;
            end
          end

          S_FIRE: begin
            if (timer == FIRE_LAST) begin
              state <= S_WAIT_STOP;
              drv   <= drive_of(S_WAIT_STOP);
              timer <= '0;
            end
          end

          S_WAIT_STOP: begin
            // A hit on the expiry cycle still counts as a real stop event.
            if (comparator_hit) begin
              state <= S_READOUT;
              drv   <= drive_of(S_READOUT);
              timer <= '0;
            end else if (timer == TIMEOUT_LAST) begin
              result_valid   <= 1'b1;
              result_timeout <= 1'b1;
              result_data    <= '0;
              shots_done     <= shots_next;
              state          <= S_COOLDOWN;
              drv            <= drive_of(S_COOLDOWN);
              timer          <= '0;
            end
          end

          S_READOUT: begin
            // No timeout here: the handshake always completes, even on abort.
            timer <= '0;
            if (abort) begin
              abort_pending <= 1'b1;
            end
            if (rd_ack) begin
              result_valid   <= 1'b1;
              result_timeout <= 1'b0;
              result_data    <= rd_data;
              shots_done     <= shots_next;
              abort_pending  <= 1'b0;
              if (abort || abort_pending) begin
                state <= S_IDLE;
                drv   <= drive_of(S_IDLE);
              end else begin
                state <= S_COOLDOWN;
                drv   <= drive_of(S_COOLDOWN);
              end
            end
          end

          S_COOLDOWN: begin
            if (timer == COOLDOWN_LAST) begin
              timer <= '0;
              if (shots_done < burst_target) begin
                state <= S_CHARGE;
                drv   <= drive_of(S_CHARGE);
              end else begin
                state <= S_IDLE;
                drv   <= drive_of(S_IDLE);
              end
            end
          end

          default: begin
            state <= S_IDLE;
            drv   <= drive_of(S_IDLE);
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule
